seq_detect_prog: RTL and testbench
==================================

// Module: seq_detect_prog
// PURPOSE
//  Programmable serial sequence detector: matches a run-time pattern of 1..MAX_LEN bits
//  on a qualified 1-bit stream, in overlapping or non-overlapping mode.
//  Counts matches in a saturating counter.
//  Successor to the fixed 4-bit "1011" detector FSM. Sits on a serial input lane,
//  feeding a status/interrupt block.
// PARAMETERS
//  MAX_LEN      8          maximum pattern length in bits (>=2)
//  CNT_W        8          width of match counter
//  DEF_PATTERN  8'h0B      pattern loaded at reset (LSB = last bit received)
//  DEF_LEN      4          pattern length loaded at reset
//  DEF_OVERLAP  1          overlap mode loaded at reset
// PORTS
//  clk           in   1         clock, all logic on posedge
//  reset         in   1         synchronous, active-high reset
//  cfg_load      in   1         1-cycle strobe: latch cfg_* and flush history
//  cfg_pattern   in   MAX_LEN   pattern; bit[len-1] = first bit in time, bit[0] = last
//  cfg_len       in   LEN_W     pattern length, LEN_W = $clog2(MAX_LEN+1)
//  cfg_overlap   in   1         1: matched bits may start next match; 0: they may not
//  inp_valid     in   1         inp_bit is sampled only when high
//  inp_bit       in   1         serial data bit
//  cnt_clr       in   1         clear match counter
//  seq_seen      out  1         registered 1-cycle pulse per match
//  match_count   out  CNT_W     number of matches, saturating
//  cnt_sat       out  1         match_count == all ones
// BEHAVIOUR
//  Reset:
//   - seq_seen=0, match_count=0, cnt_sat=0, history=0, fill=0.
//   - Active config = DEF_PATTERN / DEF_LEN / DEF_OVERLAP.
//  Active config regs:
//   - pat, len, ovl are written only on cfg_load.
//   - cfg_len > MAX_LEN is stored as MAX_LEN.
//   - cfg_len == 0 disables detection (never matches).
//   - cfg_pattern bits above len are ignored.
//   - cfg_load also clears history and fill.
//   - cfg_load does not affect match_count.
//  Accepted bit (inp_valid=1 and no cfg_load):
//   - hist <= {hist[MAX_LEN-2:0], inp_bit}.
//   - fill <= min(fill+1, MAX_LEN).
//  Match (combinational on the accepted bit):
//   - Requires len != 0, fill+1 >= len, and new hist[len-1:0] == pat[len-1:0].
//   - seq_seen=1 in the next cycle only; latency = 1 clk from the accepting edge.
//   - Back-to-back matches give consecutive seq_seen pulses.
//  Overlap:
//   - ovl=1: fill continues normally after a match.
//   - ovl=0: fill <= 0 on a match, so the next match needs len fresh bits.
//  inp_valid=0: hist, fill and the match logic hold; seq_seen=0 next cycle.
//  match_count: +1 per match; holds at 2^CNT_W-1 and never wraps; cnt_sat = (count == max).
//  Precedence:
//   - reset > cfg_load > inp_valid. A bit arriving with cfg_load is discarded.
//   - cnt_clr wins over a same-cycle match: count = 0.
//   - seq_seen still pulses for a match that coincides with cnt_clr.
//  Reset mid-sequence: a partial match is lost; detection restarts from an empty history.
// STRUCTURE
//  Package seq_detect_pkg holds:
//   - LEN_W as $clog2(MAX_LEN+1).
//   - Default config constants.
//   - A mask function: len -> MAX_LEN-bit low-ones mask.
//  Sub-module sat_counter (CNT_W, inc, clr, count, sat) implements the match counter.
//  Top level holds config regs, history shift register, fill counter and match compare.
// TESTING
//  1 Reset defaults, overlap. Stream 1,0,1,1,0,1,1, all valid -> seq_seen after bits 4 and 7; count=2.
//  2 cfg_overlap=0, pattern 1011, len 4, same stream -> seq_seen after bit 4 only; count=1.
//  3 Gaps. Pattern 1011 with inp_valid=0 cycles between each bit -> one pulse, 1 clk after last valid bit.
//  4 Length limits.
//     - cfg_len=8, pattern 8'hA5, stream A5 MSB first -> 1 pulse.
//     - cfg_len=0 -> none on any stream.
//     - cfg_len=15 -> behaves as len 8.
//  5 Saturation, CNT_W=3.
//     - Pattern 11, len 2, overlap, 10 ones -> 9 pulses; count sticks at 7, cnt_sat=1.
//     - cnt_clr with a match pulse -> count 0.
//  6 Flush. cfg_load or reset after bits 1,0,1; then bit 1 -> no match (history flushed).

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
package seq_detect_pkg;

  // Widest pattern the mask helper can describe.
  localparam int unsigned MASK_W = 32;

  // Default build and reset-time configuration.
  localparam int unsigned PKG_MAX_LEN     = 8;
  localparam int unsigned PKG_CNT_W       = 8;
  localparam int unsigned LEN_W           = $clog2(PKG_MAX_LEN + 1);
  localparam logic [7:0]  PKG_DEF_PATTERN = 8'h0B;
  localparam int unsigned PKG_DEF_LEN     = 4;
  localparam logic        PKG_DEF_OVERLAP = 1'b1;

  // Low-ones mask: bit i set for every i < n.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned n);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  assign sat = (count == '1);

  // Count increments, holding at all-ones; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector with overlap control and a
// saturating match counter.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN              = PKG_MAX_LEN,
  parameter int unsigned CNT_W                = PKG_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN   = MAX_LEN'(PKG_DEF_PATTERN),
  parameter int unsigned DEF_LEN              = PKG_DEF_LEN,
  parameter logic        DEF_OVERLAP          = PKG_DEF_OVERLAP,
  localparam int unsigned LW                  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               inp_valid,
  input  logic               inp_bit,
  input  logic               cnt_clr,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               cnt_sat
);

  // Active configuration.
  logic [MAX_LEN-1:0] pat;
  logic [LW-1:0]      len;
  logic               ovl;

  // Bit history (bit 0 = newest) and number of valid history bits.
  logic [MAX_LEN-1:0] hist;
  logic [LW-1:0]      fill;

  logic [LW-1:0]      cfg_len_c;
  logic [MAX_LEN-1:0] cfg_pat_c;
  logic [MAX_LEN-1:0] act_mask;
  logic [MAX_LEN-1:0] hist_next;
  logic [LW:0]        fill_inc;
  logic [LW-1:0]      fill_next;
  logic               accept;
  logic               match;

  // Clamp the requested length and drop pattern bits beyond it.
  always_comb begin
    cfg_len_c = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
    cfg_pat_c = cfg_pattern & MAX_LEN'(len_mask(32'(cfg_len_c)));
  end

  // Match decision on the bit being accepted this cycle, and the history/fill update it implies.
  always_comb begin
    accept    = inp_valid && !cfg_load;
    hist_next = {hist[MAX_LEN-2:0], inp_bit};
    act_mask  = MAX_LEN'(len_mask(32'(len)));
    fill_inc  = {1'b0, fill} + (LW+1)'(1);
    match     = accept && (len != '0) && (fill_inc >= {1'b0, len}) &&
                (((hist_next ^ pat) & act_mask) == '0);
    // Non-overlap restarts the fill so the next match needs len fresh bits.
    if (match && !ovl) begin
      fill_next = '0;
    end else if (fill == LW'(MAX_LEN)) begin
      fill_next = fill;
    end else begin
      fill_next = fill + LW'(1);
    end
  end

  // Configuration registers: loaded at reset and on cfg_load only.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat <= DEF_PATTERN & MAX_LEN'(len_mask(DEF_LEN));
      len <= LW'(DEF_LEN);
      ovl <= DEF_OVERLAP;
    end else if (cfg_load) begin
      pat <= cfg_pat_c;
      len <= cfg_len_c;
      ovl <= cfg_overlap;
    end
  end

  // History, fill and the registered match pulse; cfg_load flushes and discards the bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist     <= '0;
      fill     <= '0;
      seq_seen <= 1'b0;
    end else if (cfg_load) begin
      hist     <= '0;
      fill     <= '0;
      seq_seen <= 1'b0;
    end else begin
      seq_seen <= match;
      if (accept) begin
        hist <= hist_next;
        fill <= fill_next;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (cnt_clr),
    .count (match_count),
    .sat   (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_seq_detect_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned LW      = 4;
  localparam int          CMAX    = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               inp_valid;
  logic               inp_bit;
  logic               cnt_clr;
  logic               seq_seen;
  logic [CNT_W-1:0]   match_count;
  logic               cnt_sat;

  seq_detect_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .inp_valid   (inp_valid),
    .inp_bit     (inp_bit),
    .cnt_clr     (cnt_clr),
    .seq_seen    (seq_seen),
    .match_count (match_count),
    .cnt_sat     (cnt_sat)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  int pulses   = 0;

  // Reference model state: bits accepted since the last flush / non-overlap match.
  bit q[$];
  int m_pat;
  int m_len;
  bit m_ovl;
  int m_cnt;
  bit m_seen;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit model_match();
    if (m_len == 0 || q.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat  = 'h0B;
    m_len  = 4;
    m_ovl  = 1'b1;
    m_cnt  = 0;
    m_seen = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".seen"}, int'(seq_seen), int'(m_seen));
    check({tag, ".cnt"},  int'(match_count), m_cnt);
    check({tag, ".sat"},  int'(cnt_sat), (m_cnt == CMAX) ? 1 : 0);
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic cyc(input string tag, input bit ld, input int p, input int l,
                     input bit o, input bit v, input bit b, input bit c);
    bit hit;
    cfg_load    = ld;
    cfg_pattern = p[MAX_LEN-1:0];
    cfg_len     = l[LW-1:0];
    cfg_overlap = o;
    inp_valid   = v;
    inp_bit     = b;
    cnt_clr     = c;
    hit = 1'b0;
    if (ld) begin
      m_len = (l > MAX_LEN) ? MAX_LEN : l;
      m_pat = p & ((1 << m_len) - 1);
      m_ovl = o;
      q.delete();
    end else if (v) begin
      q.push_back(b);
      if (q.size() > 16) void'(q.pop_front());
      hit = model_match();
      if (hit && !m_ovl) q.delete();
    end
    m_seen = hit;
    if (c) m_cnt = 0;
    else if (hit && m_cnt < CMAX) m_cnt++;
    @(posedge clk);
    #1;
    if (seq_seen) pulses++;
    check_outputs(tag);
  endtask

  task automatic bit_in(input string tag, input bit b);
    cyc(tag, 1'b0, 0, 0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input string tag, input int p, input int l, input bit o);
    cyc(tag, 1'b1, p, l, o, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cfg_load = 1'b0; inp_valid = 1'b0; inp_bit = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs(tag);
  endtask

  task automatic send_byte(input string tag, input int v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(tag, v[i]);
  endtask

  initial begin
    int s7;
    s7 = 'b1011011;
    do_reset("reset");

    // 1: default config, overlapping
    pulses = 0;
    send_byte("t1", s7, 7);
    check("t1_pulses", pulses, 2);
    check("t1_count", int'(match_count), 2);

    // 2: non-overlap
    cyc("t2_clr", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    load("t2_ld", 'b1011, 4, 1'b0);
    pulses = 0;
    send_byte("t2", s7, 7);
    check("t2_pulses", pulses, 1);
    check("t2_count", int'(match_count), 1);

    // 3: gaps between valid bits
    load("t3_ld", 'b1011, 4, 1'b1);
    pulses = 0;
    for (int i = 3; i >= 0; i--) begin
      bit_in("t3_bit", s7[i]);
      idle("t3_gap");
      idle("t3_gap");
    end
    check("t3_pulses", pulses, 1);

    // 4: length limits
    load("t4a_ld", 'hA5, 8, 1'b1);
    pulses = 0;
    send_byte("t4a", 'hA5, 8);
    check("t4a_pulses", pulses, 1);
    load("t4b_ld", 'hA5, 0, 1'b1);
    pulses = 0;
    send_byte("t4b", 'hA5, 8);
    send_byte("t4b", 'h00, 8);
    send_byte("t4b", 'hFF, 8);
    check("t4b_pulses", pulses, 0);
    load("t4c_ld", 'hA5, 15, 1'b1);
    pulses = 0;
    send_byte("t4c", 'h05, 4);
    send_byte("t4c", 'hA5, 8);
    check("t4c_pulses", pulses, 1);

    // 5: saturation with CNT_W = 3
    cyc("t5_clr", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    load("t5_ld", 'b11, 2, 1'b1);
    pulses = 0;
    for (int i = 0; i < 10; i++) bit_in("t5", 1'b1);
    check("t5_pulses", pulses, 9);
    check("t5_count", int'(match_count), 7);
    check("t5_sat", int'(cnt_sat), 1);
    cyc("t5_clrhit", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("t5_clr_seen", int'(seq_seen), 1);
    check("t5_clr_count", int'(match_count), 0);

    // 6: flush by cfg_load and by reset
    load("t6_ld", 'b1011, 4, 1'b1);
    send_byte("t6a", 'b101, 3);
    load("t6a_ld", 'b1011, 4, 1'b1);
    pulses = 0;
    bit_in("t6a", 1'b1);
    check("t6a_pulses", pulses, 0);
    send_byte("t6b", 'b101, 3);
    do_reset("t6b_rst");
    pulses = 0;
    bit_in("t6b", 1'b1);
    check("t6b_pulses", pulses, 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        do_reset("rnd_rst");
      end else if (r < 4) begin
        int l;
        l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 3));
        cyc("rnd_ld", 1'b1, int'($urandom_range(0, 255)), l, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
      end else begin
        cyc("rnd", 1'b0, 0, 0, 1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
